// File: rtl/symbol_modulator.sv
`default_nettype none
// ============================================================================
// Module      : symbol_modulator
// Description : Serialises DATA_W-bit words MSB-first and keys the 8-bit DDS
//               carrier (Magnitude) with each bit for SAMPLES_PER_BIT clocks.
//               Keying is OOK (bit 0 -> IDLE_LEVEL) or BPSK (bit 0 ->
//               inverted carrier), selected per word by 'mode'.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1       system clock, rising edge
//   rst         in   1       synchronous active-high reset
//   Magnitude   in   8       DDS carrier sample, unsigned offset-binary
//   mode        in   1       0=OOK, 1=BPSK, captured when a word is accepted
//   data_in     in   DATA_W  word to transmit
//   data_valid  in   1       data_in valid
//   data_ready  out  1       idle, a word can be accepted this cycle
//   mod_out     out  8       modulated sample (registered)
//   bit_out     out  1       bit currently keying mod_out
//   busy        out  1       a word is being transmitted
//   frame_done  out  1       one-cycle pulse with the last sample of a word
// Configuration
//   SYMMOD_PARITY_EN : when defined, an even-parity bit (XOR of data_in) is
//                      sent after the LSB, lengthening each frame by one bit.
// ============================================================================
module symbol_modulator #(
    parameter int         DATA_W          = 8,
    parameter int         SAMPLES_PER_BIT = 16,
    parameter logic [7:0] IDLE_LEVEL      = 8'd128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        Magnitude,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [7:0]        mod_out,
    output logic              bit_out,
    output logic              busy,
    output logic              frame_done
);

`ifdef SYMMOD_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif

    // Sample counter runs SAMPLES_PER_BIT-1 .. 0; keep at least one bit wide
    // so the SAMPLES_PER_BIT=1 build still elaborates (counter stays at 0).
    localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int BL_W  = $clog2(NBITS + 1);

    localparam logic [CNT_W-1:0] C_SAMP_RELOAD = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_SAMP_ONE    = CNT_W'(1);
    localparam logic [BL_W-1:0]  C_NBITS       = BL_W'(NBITS);
    localparam logic [BL_W-1:0]  C_BL_ONE      = BL_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [NBITS-1:0] r_shreg;
    logic             r_mode_q;
    logic [BL_W-1:0]  r_bits_left;
    logic [CNT_W-1:0] r_samp_cnt;

    logic             w_accept;
    logic             w_sending;
    logic             w_last;
    logic             w_cur_bit;
    logic [NBITS-1:0] w_load_word;

    assign w_sending  = (r_state == S_SEND);
    assign w_accept   = data_valid && (r_state == S_IDLE);
    // Final sample of the final bit: frame ends on this clock edge.
    assign w_last     = w_sending && (r_samp_cnt == '0) && (r_bits_left == C_BL_ONE);
    assign w_cur_bit  = r_shreg[NBITS-1];

    assign data_ready = (r_state == S_IDLE);
    assign busy       = w_sending;

`ifdef SYMMOD_PARITY_EN
    // Parity bit sits below the LSB so it is shifted out last.
    assign w_load_word = {data_in, ^data_in};
`else
    assign w_load_word = data_in;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SEND;
            S_SEND:  if (w_last)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit serialiser and sample timing
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg     <= '0;
            r_mode_q    <= 1'b0;
            r_bits_left <= '0;
            r_samp_cnt  <= '0;
        end else if (w_accept) begin
            r_shreg     <= w_load_word;
            r_mode_q    <= mode;
            r_bits_left <= C_NBITS;
            r_samp_cnt  <= C_SAMP_RELOAD;
        end else if (w_sending) begin
            if (r_samp_cnt != '0) begin
                r_samp_cnt <= r_samp_cnt - C_SAMP_ONE;
            end else if (!w_last) begin
                r_shreg     <= r_shreg << 1;
                r_bits_left <= r_bits_left - C_BL_ONE;
                r_samp_cnt  <= C_SAMP_RELOAD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output sample register: one clock from Magnitude to mod_out.
    // In BPSK a 0 bit uses the bitwise inverse, i.e. 255-Magnitude, which
    // mirrors the carrier around the offset-binary midpoint.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mod_out    <= IDLE_LEVEL;
            bit_out    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_last;
            bit_out    <= w_sending && w_cur_bit;
            if (!w_sending) begin
                mod_out <= IDLE_LEVEL;
            end else if (w_cur_bit) begin
                mod_out <= Magnitude;
            end else if (r_mode_q) begin
                mod_out <= ~Magnitude;
            end else begin
                mod_out <= IDLE_LEVEL;
            end
        end
    end

endmodule
`default_nettype wire
